// File: rtl/pq_sched_ctrl.sv
// ---------------------------------------------------------------------------
// pq_sched_ctrl
//
// Issue controller for the event priority-queue heap. It arbitrates enqueue
// requests from NREQ event-processing cores in round-robin order and serves a
// single dequeue consumer. It enforces the heap's full/empty limits and the
// heap's post-operation hold-off. Each cycle it drives at most one heap strobe,
// and it returns every dequeued minimum on a registered output.
//
// Optional feature macro: PQ_SCHED_HWM_EN
//   defined   - hwm holds the largest heap_count seen since the last reset.
//   undefined - hwm is tied to 0 and no register is built.
//
// Ports:
//   CLK         in   1        clock; all logic runs on posedge
//   rst_n       in   1        asynchronous active-low reset
//   enq_req     in   NREQ     per-requester enqueue valid, held until acked
//   enq_data    in   NREQ*DW  requester i data at [i*DW +: DW]
//   enq_ack     out  NREQ     one-hot grant, combinational
//   deq_req     in   1        consumer dequeue request, held until acked
//   deq_ack     out  1        dequeue issue, combinational
//   deq_valid   out  1        registered one-cycle pulse after deq_ack
//   deq_data    out  DW       registered dequeued value (held between pulses)
//   heap_enq    out  1        heap insert strobe
//   heap_deq    out  1        heap extract-min strobe
//   heap_data   out  DW       heap insert data, 0 when not enqueuing
//   heap_out    in   DW       heap root (current minimum)
//   heap_count  in   CW       heap occupancy
//   full        out  1        heap_count == CAP
//   empty       out  1        heap_count == 0
//   hwm         out  CW       occupancy high-water mark
// ---------------------------------------------------------------------------
module pq_sched_ctrl #(
    parameter int NREQ    = 4,
    parameter int DW      = 16,
    parameter int CW      = 5,
    parameter int CAP     = 31,
    parameter int DEQ_GAP = 2
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   enq_req,
    input  logic [NREQ*DW-1:0] enq_data,
    output logic [NREQ-1:0]   enq_ack,
    input  logic              deq_req,
    output logic              deq_ack,
    output logic              deq_valid,
    output logic [DW-1:0]     deq_data,
    output logic              heap_enq,
    output logic              heap_deq,
    output logic [DW-1:0]     heap_data,
    input  logic [DW-1:0]     heap_out,
    input  logic [CW-1:0]     heap_count,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     hwm
);

    localparam int unsigned NR = NREQ;
    localparam int          RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0]  GAP_INIT = 2'(DEQ_GAP - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        READY = 2'd0,
        ECOOL = 2'd1,
        DCOOL = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      gap_cnt;
    logic [RW-1:0]   rr;

    logic            grant_vld;
    logic [RW-1:0]   grant_idx;
    logic [DW-1:0]   grant_data;
    logic            deq_issue;
    logic            enq_issue;
    logic [RW-1:0]   rr_next;

    // Occupancy limits come straight from the heap's registered count.
    assign full  = (heap_count == CW'(CAP));
    assign empty = (heap_count == '0);

    // Round-robin search: first requester at or after rr, wrapping.
    always_comb begin
        int unsigned idx;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        idx        = 0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = (int'(rr) + k) % NR;
            if (!grant_vld && enq_req[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = RW'(idx);
                grant_data = enq_data[idx*DW +: DW];
            end
        end
    end

    // Dequeue has priority; it may only go from READY.
    assign deq_issue = deq_req && !empty && (state == READY);
    assign enq_issue = grant_vld && !full && !deq_issue &&
                       ((state == READY) || (state == ECOOL));

    assign deq_ack   = deq_issue;
    assign heap_deq  = deq_issue;
    assign heap_enq  = enq_issue;
    assign enq_ack   = enq_issue ? (ONE_HOT0 << grant_idx) : '0;
    assign heap_data = enq_issue ? grant_data : '0;

    assign rr_next = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + RW'(1);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= READY;
            gap_cnt   <= '0;
            rr        <= '0;
            deq_valid <= 1'b0;
            deq_data  <= '0;
        end else begin
            deq_valid <= deq_issue;
            if (deq_issue) begin
                deq_data <= heap_out;
            end
            if (enq_issue) begin
                rr <= rr_next;
            end
            unique case (state)
                READY: begin
                    if (deq_issue) begin
                        state   <= DCOOL;
                        gap_cnt <= GAP_INIT;
                    end else if (enq_issue) begin
                        state <= ECOOL;
                    end
                end
                ECOOL: begin
                    if (!enq_issue) begin
                        state <= READY;
                    end
                end
                DCOOL: begin
                    if (gap_cnt == '0) begin
                        state <= READY;
                    end else begin
                        gap_cnt <= gap_cnt - 2'd1;
                    end
                end
                default: begin
                    state   <= READY;
                    gap_cnt <= '0;
                end
            endcase
        end
    end

`ifdef PQ_SCHED_HWM_EN
    logic [CW-1:0] hwm_q;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q <= '0;
        end else if (heap_count > hwm_q) begin
            hwm_q <= heap_count;
        end
    end

    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

endmodule

// File: doc/pq_sched_ctrl.md
# pq_sched_ctrl

Issue controller for the event priority-queue heap. It arbitrates enqueue requests from `NREQ` event-processing cores round-robin and serves one dequeue consumer. It enforces the heap's full/empty limits and its post-operation hold-off. Each cycle it drives at most one `enq`/`deq` strobe into the heap and returns each dequeued minimum on a registered output.

## Interface
Parameters:
- `NREQ`, 4: number of enqueue requesters (2..8).
- `DW`, 16: event key/data width.
- `CW`, 5: heap count width.
- `CAP`, 31: heap capacity; full when `heap_count == CAP`.
- `DEQ_GAP`, 2: idle cycles forced after each dequeue (1..3).

Ports:
- `CLK`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enq_req`  in  NREQ  per-requester valid; held until acked.
- `enq_data`  in  NREQ*DW  requester i at `[i*DW +: DW]`.
- `enq_ack`  out  NREQ  one-hot, combinational, high in the issue cycle.
- `deq_req`  in  1  consumer wants the minimum; held until acked.
- `deq_ack`  out  1  combinational, high in the issue cycle.
- `deq_valid`  out  1  registered, one-cycle pulse.
- `deq_data`  out  DW  registered dequeued value.
- `heap_enq`, `heap_deq`  out  1 each  heap strobes.
- `heap_data`  out  DW  heap input data.
- `heap_out`  in  DW  heap root (current minimum).
- `heap_count`  in  CW  heap occupancy.
- `full`, `empty`  out  1 each  combinational from `heap_count`.
- `hwm`  out  CW  occupancy high-water mark (macro only).

## Operation
- FSM states:
  - READY: enq or deq may issue.
  - ECOOL: only enq may issue.
  - DCOOL: nothing issues; `gap_cnt` counts down.
- Issue decision (priority order):
  1. Deq issues if `deq_req && !empty` and state is READY.
  2. Otherwise enq issues if any `enq_req`, `!full`, and state is READY or ECOOL.
  3. Otherwise nothing issues.
- Transitions:
  - Deq issued → DCOOL with `gap_cnt = DEQ_GAP-1`.
  - Enq issued → ECOOL.
  - ECOOL with no issue → READY.
  - DCOOL at `gap_cnt == 0` → READY; otherwise decrement.
- Dequeue handshake:
  - `heap_deq = deq_ack = 1` in the issue cycle.
  - `heap_out` is captured into `deq_data` and `deq_valid` pulses the next cycle.
- Enqueue arbitration:
  - Round-robin pointer `rr` (`$clog2(NREQ)` bits).
  - Grant the first requester at index ≥ `rr`, wrapping.
  - On grant, `rr <= (g+1) mod NREQ`.
  - `heap_data = enq_data[g]`, `heap_enq = 1`, `enq_ack[g] = 1`.
- Strobe rules:
  - `heap_enq` and `heap_deq` are never both high.
  - No strobe while full/empty blocks the respective operation.
  - `heap_data` = 0 when not enqueuing.
- Boundaries:
  - Deq with `heap_count == 0`: request stalls with no ack.
  - Enq at `heap_count == CAP`: stalls; deq still proceeds.
  - Simultaneous deq and enq requests in READY: deq wins; enq issues after the hold-off.
  - `rr` wraps from NREQ-1 to 0.
  - A requester dropping `enq_req` without an ack is legal; no grant is recorded.
- Reset mid-operation clears everything. The heap is reset on the same `rst_n`, and no pending op is retained.

## Timing
- Reset values:
  - `state` = READY, `rr` = 0, `gap_cnt` = 0.
  - `deq_valid` = 0, `deq_data` = 0, `hwm` = 0.
  - Combinational outputs follow their inputs: with no requests, all strobes and acks are 0.
- Latency:
  - Ack in the same cycle as the request when eligible.
  - `deq_data` valid 1 cycle after `deq_ack`.
- Throughput:
  - Back-to-back enqs at 1/cycle.
  - Deq → next op after `DEQ_GAP` idle cycles.
  - Enq → deq needs at least one cycle between them.
- `full`/`empty` use the `heap_count` registered at the preceding edge, which already reflects every prior strobe.

## Configuration
- `PQ_SCHED_HWM_EN` defined:
  - `hwm` register tracks the maximum `heap_count` seen.
  - It updates on every posedge: `hwm <= max(hwm, heap_count)`.
  - Cleared only by reset.
- Not defined: the `hwm` port still exists, is tied to 0, and no register is built.

## Test plan
- Reset, then requester 2 enqs 0x0040 → `enq_ack = 4'b0100`, `heap_enq` and `heap_data = 0x0040` in the same cycle; next cycle state = ECOOL.
- All four requesters hold `enq_req` with `rr = 0` → grants 0,1,2,3,0 on five consecutive cycles.
- Heap holding {0x10, 0x30}, `deq_req` held → `deq_ack` at t; `deq_valid` with `deq_data = 0x10` at t+1; second `deq_ack` no earlier than t+3 (`DEQ_GAP = 2`).
- `heap_count = 31` with `enq_req = 4'b0001` → no ack and `full = 1`. Then a deq issues and `heap_count` becomes 30; the enq is acked on the first cycle state returns to READY.
- `heap_count = 0` with `deq_req` held → `deq_ack = 0` and `empty = 1`. Enq 0x0005 at t → `deq_ack` at t+2, `deq_data = 0x0005` at t+3.
- With `PQ_SCHED_HWM_EN`: 7 enqs then 3 deqs → `hwm = 7`; assert `rst_n` low mid-sequence → `hwm = 0`, `deq_valid = 0` immediately.
